// File: rtl/dmem_responder_pkg.sv
// Shared core types for the data-memory responder: FSM states, RV32I load/store
// size encodings and the decode helpers used by the responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_t;

    typedef logic [31:0] dataMem_out_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Misaligned or undefined accesses; these never touch the RAM.
    function automatic logic req_illegal(
        input logic [2:0] func3,
        input logic       wmem,
        input logic       rmem,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = 1'b0;
        if (wmem && rmem) bad = 1'b1;
        if (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111) bad = 1'b1;
        if (wmem && func3 >= 3'b011) bad = 1'b1;
        if ((func3 == LS_H || func3 == LS_HU) && addr_lo[0]) bad = 1'b1;
        if (func3 == LS_W && addr_lo != 2'b00) bad = 1'b1;
        return bad;
    endfunction

    function automatic dataMem_out_t load_extract(
        input logic [2:0]  func3,
        input logic [1:0]  lane,
        input logic [31:0] word
    );
        logic [7:0]   b;
        logic [15:0]  h;
        dataMem_out_t r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (func3)
            LS_B:    r = {{24{b[7]}}, b};
            LS_BU:   r = {24'b0, b};
            LS_H:    r = {{16{h[15]}}, h};
            LS_HU:   r = {16'b0, h};
            LS_W:    r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// Single-port synchronous data RAM: 32-bit words, per-byte write enables,
// registered read data (read-before-write on a combined access).
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: serializes one load or store at a
// time through a fixed-latency RAM, stalling the pipeline until the response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    input  logic [2:0]   func3,
    input  logic         Wmem,
    input  logic         Rmem,
    output logic         stall,
    output logic         resp_valid,
    output dataMem_out_t memOut,
    output logic         err
);

    localparam int         AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    // Handshake: a request is Wmem|Rmem seen in IDLE. stall is high from that
    // cycle until the access completes and the requester holds every request
    // input stable meanwhile; resp_valid pulses for exactly one cycle with
    // memOut/err, during which inputs are ignored.

    dmem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    func3_q, func3_d;
    logic          wmem_q, wmem_d;
    logic          err_q, err_d;

    logic          stall_c;
    logic          ram_en;
    logic [3:0]    ram_be;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        func3_d = func3_q;
        wmem_d  = wmem_q;
        err_d   = err_q;
        stall_c = 1'b0;
        ram_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Wmem || Rmem) begin
                    stall_c = 1'b1;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    func3_d = func3;
                    wmem_d  = Wmem;
                    err_d   = req_illegal(func3, Wmem, Rmem, addr[1:0]);
                    cnt_d   = '0;
                    state_d = err_d ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (cnt_q == LAST) begin
                    // RAM access on the final edge: commits a store and
                    // registers the read word for DONE.
                    ram_en  = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = wdata_q;
        case (func3_q)
            LS_B: begin
                ram_be    = 4'b0001 << addr_q[1:0];
                ram_wdata = {4{wdata_q[7:0]}};
            end
            LS_H: begin
                ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                ram_be    = 4'b1111;
                ram_wdata = wdata_q;
            end
        endcase
        ram_we = (ram_en && wmem_q) ? ram_be : 4'b0000;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            wmem_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            wmem_q  <= wmem_d;
            err_q   <= err_d;
        end
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // stall is decoded from live inputs in IDLE, so it is masked by reset too.
    always_comb begin
        stall      = stall_c && nReset;
        resp_valid = (state_q == DONE);
        err        = (state_q == DONE) && err_q;
        memOut     = '0;
        if (state_q == DONE && !err_q && !wmem_q) begin
            memOut = load_extract(func3_q, addr_q[1:0], ram_rdata);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (1 and 3 wait cycles) driven with
// directed and random accesses, checked against a word-array reference model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        nReset;
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic [2:0]  func3_i [2];
    logic        wmem_i  [2];
    logic        rmem_i  [2];
    logic        stall_o [2];
    logic        resp_o  [2];
    logic        err_o   [2];
    logic [31:0] mem_o   [2];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] exp_q[$];
    logic [31:0] d;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .nReset(nReset), .addr(addr_i[0]), .wdata(wdata_i[0]),
        .func3(func3_i[0]), .Wmem(wmem_i[0]), .Rmem(rmem_i[0]),
        .stall(stall_o[0]), .resp_valid(resp_o[0]), .memOut(mem_o[0]), .err(err_o[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .nReset(nReset), .addr(addr_i[1]), .wdata(wdata_i[1]),
        .func3(func3_i[1]), .Wmem(wmem_i[1]), .Rmem(rmem_i[1]),
        .stall(stall_o[1]), .resp_valid(resp_o[1]), .memOut(mem_o[1]), .err(err_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input bit wm, input bit rm, input logic [2:0] f3,
                                     input logic [31:0] a);
        if (wm && rm) return 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (wm && f3 >= 3'b011) return 1'b1;
        if ((f3 == LS_H || f3 == LS_HU) && (a % 2) != 0) return 1'b1;
        if (f3 == LS_W && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [31:0] a);
        int          sh;
        logic [31:0] part;
        sh = int'(a % 4) * 8;
        case (f3)
            LS_B: begin
                part = (w >> sh) & 32'hFF;
                return (part >= 32'd128) ? part - 32'd256 : part;
            end
            LS_BU: return (w >> sh) & 32'hFF;
            LS_H: begin
                part = (w >> sh) & 32'hFFFF;
                return (part >= 32'd32768) ? part - 32'd65536 : part;
            end
            LS_HU: return (w >> sh) & 32'hFFFF;
            LS_W:  return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [31:0] a);
        int          sh;
        logic [31:0] m;
        sh = int'(a % 4) * 8;
        case (f3)
            LS_B:    m = 32'hFF;
            LS_H:    m = 32'hFFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return (w & ~(m << sh)) | ((wd & m) << sh);
    endfunction

    // One complete request on instance sel; returns the observed memOut.
    task automatic access(input int sel, input bit wm, input bit rm, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input string tag,
                          output logic [31:0] obs);
        int          idx;
        int          busy;
        int          exp_busy;
        bit          e;
        bit          got;
        logic [31:0] exp_data;
        idx      = int'((a / 4) % DEPTH);
        e        = model_err(wm, rm, f3, a);
        exp_busy = e ? 0 : (sel == 0 ? 1 : 3);
        exp_data = 32'h0;
        if (!e && rm) exp_data = model_load(model_mem[sel][idx], f3, a);
        if (!e && wm) model_mem[sel][idx] = model_store(model_mem[sel][idx], wd, f3, a);
        exp_q.push_back(exp_data);

        @(negedge clk);
        addr_i[sel]  = a;
        wdata_i[sel] = wd;
        func3_i[sel] = f3;
        wmem_i[sel]  = wm;
        rmem_i[sel]  = rm;
        #1;
        check({tag, ":req_stall"}, 32'(stall_o[sel]), 32'd1);
        busy = 0;
        got  = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            #1;
            if (resp_o[sel]) begin
                got = 1'b1;
            end else begin
                busy++;
                check({tag, ":busy_stall"}, 32'(stall_o[sel]), 32'd1);
                check({tag, ":busy_out"}, mem_o[sel] | 32'(err_o[sel]), 32'd0);
            end
        end
        obs      = mem_o[sel];
        exp_data = exp_q.pop_front();
        if (!got) begin
            check({tag, ":timeout"}, 32'(resp_o[sel]), 32'd1);
        end else begin
            check({tag, ":busy_cycles"}, 32'(busy), 32'(exp_busy));
            check({tag, ":done_stall"}, 32'(stall_o[sel]), 32'd0);
            check({tag, ":err"}, 32'(err_o[sel]), 32'(e));
            check({tag, ":memOut"}, mem_o[sel], exp_data);
        end
        wmem_i[sel]  = 1'b0;
        rmem_i[sel]  = 1'b0;
        addr_i[sel]  = $urandom;
        wdata_i[sel] = $urandom;
        @(posedge clk);
        #1;
        check({tag, ":pulse_end"}, 32'(resp_o[sel]), 32'd0);
    endtask

    initial begin
        nReset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            addr_i[s]  = '0;
            wdata_i[s] = '0;
            func3_i[s] = '0;
            wmem_i[s]  = 1'b0;
            rmem_i[s]  = 1'b0;
        end

        // Reset values
        #3 nReset = 1'b0;
        #5;
        for (int s = 0; s < 2; s++) begin
            check("rst_stall", 32'(stall_o[s]), 32'd0);
            check("rst_resp", 32'(resp_o[s]), 32'd0);
            check("rst_err", 32'(err_o[s]), 32'd0);
            check("rst_memOut", mem_o[s], 32'd0);
        end
        @(negedge clk);
        nReset = 1'b1;

        // Give a known value to the words the random phase uses
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                access(s, 1'b1, 1'b0, LS_W, 32'(w * 4), $urandom, "init", d);
            end
        end

        // Word store/load round trip
        access(0, 1'b1, 1'b0, LS_W, 32'h10, 32'hDEADBEEF, "sw10", d);
        access(0, 1'b0, 1'b1, LS_W, 32'h10, 32'h0, "lw10", d);
        check("lw10_const", d, 32'hDEADBEEF);

        // Byte store into lane 3 and the three loads of it
        access(0, 1'b1, 1'b0, LS_W, 32'h10, 32'h11223344, "sw10b", d);
        access(0, 1'b1, 1'b0, LS_B, 32'h13, 32'h00000080, "sb13", d);
        access(0, 1'b0, 1'b1, LS_B, 32'h13, 32'h0, "lb13", d);
        check("lb13_const", d, 32'hFFFFFF80);
        access(0, 1'b0, 1'b1, LS_BU, 32'h13, 32'h0, "lbu13", d);
        check("lbu13_const", d, 32'h00000080);
        access(0, 1'b0, 1'b1, LS_W, 32'h10, 32'h0, "lw10b", d);
        check("lw10b_const", d, 32'h80223344);

        // Misaligned half, conflicting request, undefined load size
        access(0, 1'b0, 1'b1, LS_H, 32'h11, 32'h0, "lh11_err", d);
        access(0, 1'b1, 1'b1, LS_W, 32'h10, 32'h55555555, "wr_rd_err", d);
        access(0, 1'b0, 1'b1, 3'b011, 32'h10, 32'h0, "f3_011_err", d);
        access(0, 1'b1, 1'b0, LS_HU, 32'h10, 32'h66666666, "st_hu_err", d);
        access(0, 1'b0, 1'b1, LS_W, 32'h10, 32'h0, "lw10c", d);
        check("lw10c_const", d, 32'h80223344);

        // Address wrap on the 3-wait-cycle instance
        access(1, 1'b1, 1'b0, LS_W, 32'h1000, 32'h5, "sw1000", d);
        access(1, 1'b0, 1'b1, LS_W, 32'h0, 32'h0, "lw0_wrap", d);
        check("lw0_wrap_const", d, 32'h5);

        // Reset in the middle of a store's ACCESS phase
        access(1, 1'b1, 1'b0, LS_W, 32'h20, 32'h12345678, "sw20", d);
        @(negedge clk);
        addr_i[1]  = 32'h20;
        wdata_i[1] = 32'hAAAA5555;
        func3_i[1] = LS_W;
        wmem_i[1]  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 nReset = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall_o[1]), 32'd0);
        check("mid_rst_resp", 32'(resp_o[1]), 32'd0);
        wmem_i[1] = 1'b0;
        #1 nReset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_resp", 32'(resp_o[1]), 32'd0);
        end
        access(1, 1'b0, 1'b1, LS_W, 32'h20, 32'h0, "lw20", d);
        check("lw20_const", d, 32'h12345678);

        // Random traffic over the initialised words, with aliasing high bits
        for (int i = 0; i < 160; i++) begin
            int          sel;
            int          op;
            bit          wm;
            bit          rm;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [2:0]  legal [5];
            legal = '{LS_B, LS_H, LS_W, LS_BU, LS_HU};
            sel = i % 2;
            op  = $urandom_range(0, 9);
            wm  = (op < 4) || (op == 9);
            rm  = (op >= 4);
            f3  = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)]
                                              : 3'($urandom_range(0, 7));
            a   = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 2) == 0) a = a | 32'($urandom_range(0, 3));
            access(sel, wm, rm, f3, a, $urandom, "rand", d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: data memory size in 32-bit words; power of two.
REQ-002 Parameter WAIT_CYCLES, default 1: memory access cycles per request; range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 addr  input  32  byte address; driven from the EXE-stage result field.
REQ-006 wdata  input  32  store data; driven from the EXE-stage rs2 field.
REQ-007 func3  input  3  access size and sign (RV32I load/store encoding).
REQ-008 Wmem  input  1  store request.
REQ-009 Rmem  input  1  load request.
REQ-010 stall  output  1  holds the pipeline; the requester keeps all request inputs stable while high.
REQ-011 resp_valid  output  1  one-cycle pulse; access complete.
REQ-012 memOut  output  32  load result as dataMem_out_t; 0 for stores and errors.
REQ-013 err  output  1  valid with resp_valid; access was misaligned or illegal.

Function
REQ-014 FSM states: IDLE, ACCESS, DONE.
REQ-015 IDLE with Wmem|Rmem high: capture the request, assert stall combinationally in that cycle, and go to ACCESS. If the request is an error, go directly to DONE instead.
REQ-016 ACCESS: stall high; a counter runs from 0 to WAIT_CYCLES-1; on its last edge, commit any store and latch the read data, then go to DONE.
REQ-017 DONE: stall low; resp_valid=1; memOut/err valid; inputs ignored; return to IDLE next edge.
REQ-018 Legal request latency: request seen in cycle N; stall high in cycles N..N+WAIT_CYCLES; resp_valid in cycle N+WAIT_CYCLES+1.
REQ-019 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around, no error).
REQ-020 Loads: 000 lb and 100 lbu select byte lane addr[1:0]; 001 lh and 101 lhu select half addr[1]; 010 lw; lb/lh sign-extend, lbu/lhu zero-extend.
REQ-021 Stores: 000 sb writes lane addr[1:0]; 001 sh writes lanes {addr[1],0}..+1 from wdata[15:0]; 010 sw writes all lanes; unwritten lanes are unchanged.
REQ-022 Error conditions: half access with addr[0]=1; word access with addr[1:0]≠0; func3 011/110/111; store func3 ≥ 011; Wmem&Rmem both high.
REQ-023 Error behaviour: 1-cycle stall (cycle N only), DONE in N+1 with err=1 and memOut=0; memory not modified.
REQ-024 Outside DONE: resp_valid=0, err=0, memOut=0.
REQ-025 Load immediately after a store to the same word returns the stored data; no bypass is needed because accesses are serialized.

Reset
REQ-026 nReset low: FSM to IDLE, counter 0, stall/resp_valid/err=0, memOut=0, immediately and asynchronously.
REQ-027 Reset during ACCESS before the commit edge: the store is aborted and memory is unchanged; no response is issued.
REQ-028 Memory array contents are not reset.

Structure
REQ-029 dmem_state_t (FSM enum) and func3 size constants (LS_B, LS_H, LS_W, LS_BU, LS_HU) are defined in the shared core types package.
REQ-030 One sub-module dmem_sram: single-port synchronous RAM, 32-bit, 4 byte-write-enables, registered read; contains no reset logic.

Verification
REQ-031 WAIT_CYCLES=1: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> stall 2 cycles per request; memOut=0xDEADBEEF, err=0.
REQ-032 sb 0x80 at 0x13 over word 0x11223344, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80223344.
REQ-033 lh at 0x11 -> 1 stall cycle, err=1, memOut=0; next lw of that word returns the unchanged value.
REQ-034 WAIT_CYCLES=3, DEPTH_WORDS=1024: sw 0x5 to 0x1000, lw 0x0 -> returns 0x5 (wrap-around); stall high 4 cycles.
REQ-035 Wmem=Rmem=1 -> err=1 with no memory change; func3=011 load -> err=1.
REQ-036 nReset pulsed mid-ACCESS of sw 0xAAAA5555 to 0x20 -> stall drops at once, no resp_valid; later lw 0x20 returns the old value.
